fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the async FIFO among NUM_REQ producers in the wr_clk domain.
- Each producer uses a valid/ready handshake.
- The arbiter grants one producer a bounded burst, then drives the FIFO's wr_en and data_in, and throttles on full.
- It sits between the producer blocks and the FIFO write side and replaces direct wr_en wiring.

Parameters:
- data_width, 8, FIFO data word width.
- NUM_REQ, 4, number of producers (2..8).
- MAX_BURST, 4, maximum words accepted per grant (1..16).

Ports:
- clk  input  1  write-domain clock (FIFO wr_clk).
- rst  input  1  synchronous reset, active-low (asserted when rst==0, sampled on the clk rising edge).
- req_valid  input  NUM_REQ  per-producer word-available flag.
- req_data  input  NUM_REQ*data_width  packed producer data; producer i occupies bits [i*data_width +: data_width].
- req_ready  output  NUM_REQ  per-producer accept; one-hot or zero.
- full  input  1  FIFO full flag.
- wr_en  output  1  FIFO write enable.
- data_in  output  data_width  FIFO write data.
- grant_id  output  $clog2(NUM_REQ)  index of the current owner; valid while busy.
- busy  output  1  a burst is in progress.

Behaviour:
- Transfer rule: a word moves on a clk edge where req_valid[i] and req_ready[i] are both 1. On that edge wr_en==1 and data_in==req_data[i].
- FSM states:
  - IDLE: no owner. req_ready=0, wr_en=0, busy=0.
  - BURST: owner is registered in grant_id. busy=1.
- IDLE -> BURST: taken on any cycle where req_valid != 0.
  - Owner = first i with req_valid[i]=1, searching cyclically from last_owner+1.
  - Burst counter cleared to 0.
  - Arbitration costs exactly one cycle: the earliest first transfer is the cycle after the request is seen in IDLE.
- Combinational outputs in BURST (no register stage, so full is honoured the same cycle):
  - req_ready[grant_id] = !full.
  - wr_en = req_valid[grant_id] & !full.
  - data_in = req_data[grant_id].
- Outputs in IDLE: data_in = 0.
- Burst counter: increments on each transfer. Width is $clog2(MAX_BURST+1).
- BURST -> IDLE on either of:
  - the MAX_BURST-th transfer of the burst (the counter reaches MAX_BURST-1 as that transfer occurs), or
  - req_valid[grant_id]==0 in a BURST cycle with full==0. The owner has gone idle; no transfer occurs that cycle.
- On BURST -> IDLE: last_owner <= grant_id.
- full held high in BURST:
  - Stay in BURST, no transfer, counter holds.
  - A valid drop while full==1 does not end the burst. Owner retention during backpressure is intentional.
- Other requesters' req_ready are always 0. A non-owner asserting valid is ignored until the next arbitration.
- Fairness: after a burst by producer k, producer k has lowest priority at the next arbitration. Worst-case wait for a continuously valid producer is (NUM_REQ-1)*(MAX_BURST+1) transfer-free-of-full cycles.
- Reset (rst==0 at an edge):
  - state=IDLE, last_owner=NUM_REQ-1 (so producer 0 wins first), counter=0, grant_id=0.
  - Outputs: busy=0, req_ready=0, wr_en=0, data_in=0.
  - Reset mid-burst abandons the burst. No partial-state carryover; wr_en is low in the cycle after the reset edge.
- Simultaneous events:
  - The MAX_BURST-th transfer and other producers' requests in the same cycle: exit to IDLE; arbitration happens in the IDLE cycle.
  - A single active producer still passes through IDLE between bursts (one-cycle bubble every MAX_BURST words).
- MAX_BURST=1: every transfer returns to IDLE.

Decomposition:
- Shared package fifo_arb_pkg:
  - state enum arb_state_t {IDLE, BURST}.
  - function rr_pick(req, last) returning index and a found flag.
  - constants derived from NUM_REQ for index width.
- One natural sub-module: rr_priority_sel. Combinational rotate-and-priority-encode of req_valid from last_owner+1. Instantiated once.
- The FSM, counter and muxing stay in fifo_wr_arbiter.
- Reuse the existing fifo_if Tb modport for the FIFO side of the bench. The arbiter output drives the wr_en and data_in signals, and samples full.

Test Plan:
1. Reset, then req_valid=4'b0001, producer 0 data 0x10..0x17 continuous, full=0:
   - Grant 0.
   - Writes 0x10,0x11,0x12,0x13; one IDLE bubble; then 0x14..0x17.
   - wr_en pattern 1111_0_1111 after the first IDLE cycle.
2. All four valid continuously, data = {id,seq} (e.g. 0x00,0x01.. for producer 0; 0x10.. for producer 1):
   - Grant order 0,1,2,3,0.
   - Each grant writes exactly 4 words; 5 cycles per grant.
3. Producer 1 in burst after 2 transfers; full=1 for 3 cycles; producer 1 drops valid during full:
   - wr_en=0 and req_ready=0 for 3 cycles; grant_id stays 1.
   - After full deasserts with valid low: exit to IDLE, total 2 words written.
4. Producer 2 alone sends 2 words then drops valid at word 3:
   - Burst ends after 2 writes; back to IDLE next cycle; last_owner=2.
   - Next arbitration with req_valid=4'b0101 grants producer 0.
5. Assert rst=0 during the second transfer of a burst:
   - The following cycle shows wr_en=0, busy=0, req_ready=0.
   - After release with req_valid=4'b1000, grant goes to producer 3 and its first write appears 2 cycles later.
6. Non-owner valid during a burst (owner 0, producer 3 valid):
   - req_ready[3]=0 throughout and no write of producer 3 data.
   - Producer 3 is granted at the next arbitration.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Combinational helpers only; no latency of their own.
// No flow control here; users apply backpressure around these helpers.
package fifo_arb_pkg;

    // Largest supported producer count, and the index width that covers it.
    localparam int MAX_REQ   = 8;
    localparam int MAX_IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    // Round-robin pick: first set bit of req at or after last+1, wrapping
    // within the n active producers.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                         input logic [MAX_IDX_W-1:0] last,
                                         input int                   n);
        rr_pick_t r;
        int       c;
        r = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            c = (int'(last) + k) % n;
            if ((k <= n) && !r.found && req[c[MAX_IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = c[MAX_IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_sel.sv
// Rotate-and-priority-encode of the request vector starting after last_i.
// Purely combinational, zero cycles.
// No backpressure; the caller decides when the pick is used.
module rr_priority_sel
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               found_o
);

    rr_pick_t pick;

    // Widen to the package's fixed-size helper and narrow the answer back.
    always_comb begin
        pick    = rr_pick(MAX_REQ'(req_i), MAX_IDX_W'(last_i), NUM_REQ);
        idx_o   = pick.idx[IDX_W-1:0];
        found_o = pick.found;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin share of one FIFO write port among NUM_REQ producers, bounded bursts.
// One arbitration cycle per grant; transfers are combinational from owner to FIFO.
// full stalls the owner in the same cycle; non-owners always see ready low.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int data_width = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4,
    parameter int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*data_width-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          full,
    output logic                          wr_en,
    output logic [data_width-1:0]         data_in,
    output logic [IDX_W-1:0]              grant_id,
    output logic                          busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_q,  last_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic             owner_vld;
    logic             xfer;
    logic             last_word;

    rr_priority_sel #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_sel (
        .req_i   (req_valid),
        .last_i  (last_q),
        .idx_o   (sel_idx),
        .found_o (sel_found)
    );

    assign busy      = (state_q == BURST);
    assign grant_id  = grant_q;
    assign owner_vld = req_valid[grant_q];
    assign xfer      = busy && owner_vld && !full;
    assign last_word = (cnt_q == CNT_W'(MAX_BURST - 1));
    assign wr_en     = xfer;

    // Owner-to-FIFO muxing; only the owner ever sees ready, and only when not full.
    always_comb begin
        req_ready = '0;
        data_in   = '0;
        if (busy) begin
            data_in = req_data[int'(grant_q)*data_width +: data_width];
            if (!full) begin
                req_ready[grant_q] = 1'b1;
            end
        end
    end

    // Burst FSM: arbitrate in IDLE, leave BURST on the last word or when the
    // owner goes idle with room in the FIFO (a drop under full keeps the grant).
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d = BURST;
                    grant_d = sel_idx;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                if (!full) begin
                    if (!owner_vld || last_word) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset; producer 0 wins first.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a write scoreboard.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// full is driven directly to exercise backpressure.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        full;
    logic        wr_en;
    logic [7:0]  data_in;
    logic [1:0]  grant_id;
    logic        busy;

    logic [7:0]  pd [4];
    logic [3:0]  ack;
    logic [7:0]  exp_q [$];
    int          n_vec;
    int          n_err;
    logic [9:0]  pat;

    fifo_wr_arbiter #(
        .data_width (8),
        .NUM_REQ    (4),
        .MAX_BURST  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .full      (full),
        .wr_en     (wr_en),
        .data_in   (data_in),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb req_data = {pd[3], pd[2], pd[1], pd[0]};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Falling-edge sample: scoreboard any write, remember producer handshakes.
    task automatic sample();
        logic [7:0] e;
        @(negedge clk);
        ack = req_valid & req_ready;
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $error("FAIL unexpected_write: observed data_in %0h with empty scoreboard", data_in);
            end else begin
                e = exp_q.pop_front();
                chk("wr_data", {24'h0, data_in}, {24'h0, e});
            end
        end
    endtask

    // Advance one edge; producers that handshook present their next word.
    task automatic adv();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (ack[i]) pd[i] = pd[i] + 8'h1;
        end
        ack = '0;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req_valid = '0;
        full      = 1'b0;
        adv();
        sample();
        chk("rst_busy",      {31'h0, busy},     0);
        chk("rst_wr_en",     {31'h0, wr_en},    0);
        chk("rst_req_ready", {28'h0, req_ready}, 0);
        chk("rst_data_in",   {24'h0, data_in},  0);
        chk("rst_grant_id",  {30'h0, grant_id}, 0);
        adv();
        rst = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        ack   = '0;
        rst   = 1'b0;
        req_valid = '0;
        full  = 1'b0;
        for (int i = 0; i < 4; i++) pd[i] = 8'h0;

        // 1: single producer, two bursts separated by one IDLE bubble.
        do_reset();
        pd[0] = 8'h10;
        for (int w = 0; w < 8; w++) exp_q.push_back(8'h10 + 8'(w));
        req_valid = 4'b0001;
        pat = '0;
        for (int c = 0; c < 10; c++) begin
            sample();
            pat = {pat[8:0], wr_en};
            if (c == 1) chk("t1_grant", {30'h0, grant_id}, 0);
            adv();
        end
        chk("t1_wr_pattern", {22'h0, pat}, 32'b0111101111);
        req_valid = '0;
        sample();
        chk("t1_idle_after", {31'h0, busy}, 0);
        adv();

        // 2: all four producers continuously valid; rotation 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < 4; i++) pd[i] = 8'(i << 4);
        for (int g = 0; g < 5; g++)
            for (int w = 0; w < 4; w++)
                exp_q.push_back(8'(((g % 4) << 4) + (g / 4) * 4 + w));
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 5; c++) begin
                sample();
                if (c == 0) chk("t2_gap_busy", {31'h0, busy}, 0);
                if (c == 1) chk("t2_grant", {30'h0, grant_id}, 32'(g % 4));
                if (c >= 1) chk("t2_wr_en", {31'h0, wr_en}, 1);
                adv();
            end
        end
        req_valid = '0;
        sample();
        adv();

        // 3: producer 1 stalled by full after two words, drops valid under full.
        do_reset();
        pd[1] = 8'h40;
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h41);
        req_valid = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            sample();
            adv();
        end
        full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) req_valid = '0;
            sample();
            chk("t3_full_wr_en", {31'h0, wr_en},     0);
            chk("t3_full_ready", {28'h0, req_ready}, 0);
            chk("t3_full_grant", {30'h0, grant_id},  1);
            chk("t3_full_busy",  {31'h0, busy},      1);
            adv();
        end
        full = 1'b0;
        sample();
        chk("t3_exit_wr_en", {31'h0, wr_en}, 0);
        adv();
        sample();
        chk("t3_idle", {31'h0, busy}, 0);
        chk("t3_words", exp_q.size(), 0);
        adv();

        // 4: producer 2 sends two words then goes idle; 0101 then grants 0.
        pd[2] = 8'h50;
        exp_q.push_back(8'h50);
        exp_q.push_back(8'h51);
        exp_q.push_back(8'h60);
        req_valid = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            sample();
            if (c == 1) chk("t4_grant2", {30'h0, grant_id}, 2);
            adv();
        end
        req_valid = '0;
        sample();
        chk("t4_drop_wr_en", {31'h0, wr_en}, 0);
        adv();
        pd[0] = 8'h60;
        req_valid = 4'b0101;
        sample();
        chk("t4_idle_busy", {31'h0, busy}, 0);
        adv();
        sample();
        chk("t4_grant0", {30'h0, grant_id}, 0);
        adv();
        req_valid = '0;
        sample();
        adv();
        sample();
        adv();

        // 5: reset on the second transfer of a burst, then producer 3 alone.
        pd[1] = 8'h80;
        exp_q.push_back(8'h80);
        exp_q.push_back(8'h81);
        req_valid = 4'b0010;
        for (int c = 0; c < 2; c++) begin
            sample();
            adv();
        end
        rst = 1'b0;
        sample();
        adv();
        sample();
        chk("t5_rst_wr_en", {31'h0, wr_en},     0);
        chk("t5_rst_busy",  {31'h0, busy},      0);
        chk("t5_rst_ready", {28'h0, req_ready}, 0);
        adv();
        rst = 1'b1;
        pd[3] = 8'h90;
        exp_q.push_back(8'h90);
        req_valid = 4'b1000;
        sample();
        chk("t5_arb_wr_en", {31'h0, wr_en}, 0);
        adv();
        sample();
        chk("t5_first_wr", {31'h0, wr_en}, 1);
        chk("t5_grant3", {30'h0, grant_id}, 3);
        adv();
        req_valid = '0;
        sample();
        adv();
        sample();
        adv();

        // 6: producer 3 valid during producer 0's burst is held off, then granted.
        pd[0] = 8'hA0;
        pd[3] = 8'hB0;
        for (int w = 0; w < 4; w++) exp_q.push_back(8'hA0 + 8'(w));
        exp_q.push_back(8'hB0);
        req_valid = 4'b0001;
        sample();
        adv();
        req_valid = 4'b1001;
        for (int c = 0; c < 4; c++) begin
            sample();
            chk("t6_ready3_low", {31'h0, req_ready[3]}, 0);
            chk("t6_owner0", {30'h0, grant_id}, 0);
            adv();
        end
        sample();
        adv();
        sample();
        chk("t6_grant3", {30'h0, grant_id}, 3);
        chk("t6_ready3", {28'h0, req_ready}, 32'b1000);
        adv();
        req_valid = '0;
        sample();
        adv();
        sample();
        adv();

        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
